// File: rtl/srt4_quotient_converter.sv
// On-the-fly radix-4 quotient converter for an SRT divider.
// Keeps the Q / QM pair so that no carry-propagate add is needed.
module srt4_quotient_converter #(
    parameter int NDIG = 8,
    parameter int QW   = 2 * NDIG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          digit_valid,
    input  logic [2:0]    digit,
    output logic          digit_ready,
    input  logic          rem_valid,
    input  logic          rem_neg,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient,
    output logic          err
);

    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_WREM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [QW-1:0] r_q;
    logic [QW-1:0] r_qm;
    logic [QW-1:0] r_quot;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic          w_ill;
    logic [2:0]    w_d;
    logic [1:0]    w_dm1;
    logic          w_acc;
    logic          w_last;
    logic          w_pos;
    logic [QW-1:0] w_q_nxt;
    logic [QW-1:0] w_qm_nxt;

    assign w_ill = (digit == 3'b011) || (digit == 3'b100) ||
                   (digit == 3'b101);
    assign w_d   = w_ill ? 3'b000 : digit;
    // Low two bits of 4+d and 3+d equal d and d-1 taken mod 4.
    assign w_dm1 = w_d[1:0] - 2'd1;
    assign w_pos = !w_d[2] && (w_d != 3'b000);

    assign w_acc  = (r_state == S_CONV) && digit_valid;
    assign w_last = w_acc && (r_cnt == CW'(NDIG - 1));

    assign w_q_nxt  = w_d[2] ? {r_qm[QW-3:0], w_d[1:0]}
                             : {r_q[QW-3:0], w_d[1:0]};
    assign w_qm_nxt = w_pos ? {r_q[QW-3:0], w_dm1}
                            : {r_qm[QW-3:0], w_dm1};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_CONV;
            S_CONV: if (w_last) w_next = S_WREM;
            S_WREM: if (rem_valid) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_qm   <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_q   <= '0;
                r_qm  <= '1;
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (w_acc) begin
                r_q   <= w_q_nxt;
                r_qm  <= w_qm_nxt;
                r_cnt <= r_cnt + CW'(1);
                if (w_ill) r_err <= 1'b1;
            end
            if (r_state == S_WREM && rem_valid) begin
                r_quot <= rem_neg ? r_qm : r_q;
            end
        end
    end

    assign digit_ready = (r_state == S_CONV);
    assign busy        = (r_state == S_CONV) || (r_state == S_WREM);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quot;
    assign err         = r_err;

endmodule

// File: tb/tb_srt4_quotient_converter.sv
// Directed bench for srt4_quotient_converter with an expected-quotient
// queue filled when the remainder sign is driven.
module tb_srt4_quotient_converter;

    localparam int NDIG = 8;
    localparam int QW   = 2 * NDIG;
    localparam int DW   = 3 * NDIG;

    logic          clk;
    logic          rst;
    logic          start;
    logic          digit_valid;
    logic [2:0]    digit;
    logic          digit_ready;
    logic          rem_valid;
    logic          rem_neg;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;
    logic          err;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [QW-1:0] sb[$];

    srt4_quotient_converter #(.NDIG(NDIG)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .digit_valid(digit_valid),
        .digit      (digit),
        .digit_ready(digit_ready),
        .rem_valid  (rem_valid),
        .rem_neg    (rem_neg),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ill(input logic [2:0] c);
        return (c == 3'b011) || (c == 3'b100) || (c == 3'b101);
    endfunction

    // Plain radix-4 positional value of the digit string, minus one
    // when the remainder is negative, reduced mod 2^QW.
    function automatic logic [QW-1:0] model(input logic [DW-1:0] dg,
                                            input logic rn);
        int acc;
        int d;
        logic [2:0] c;
        acc = 0;
        for (int i = 0; i < NDIG; i++) begin
            c = dg[3*(NDIG-1-i) +: 3];
            case (c)
                3'b110:  d = -2;
                3'b111:  d = -1;
                3'b001:  d = 1;
                3'b010:  d = 2;
                default: d = 0;
            endcase
            acc = acc * 4 + d;
        end
        if (rn) acc = acc - 1;
        return acc[QW-1:0];
    endfunction

    task automatic run(input logic [DW-1:0] dg, input logic rn,
                       input bit gaps, input bit stray);
        bit ill_seen;
        ill_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared", 32'(err), 32'd0);
        chk("ready_conv", 32'(digit_ready), 32'd1);
        for (int i = 0; i < NDIG; i++) begin
            if (gaps) begin
                repeat ($urandom_range(1, 3)) begin
                    start       = stray;
                    digit_valid = 1'b0;
                    digit       = 3'b010;
                    @(negedge clk);
                end
                start = 1'b0;
            end
            digit       = dg[3*(NDIG-1-i) +: 3];
            digit_valid = 1'b1;
            @(negedge clk);
            if (is_ill(digit)) ill_seen = 1'b1;
            chk("err_track", 32'(err), 32'(ill_seen));
        end
        digit_valid = 1'b0;
        chk("wrem_ready", 32'(digit_ready), 32'd0);
        chk("wrem_busy", 32'(busy), 32'd1);
        if (stray) begin
            digit_valid = 1'b1;
            digit       = 3'b010;
            start       = 1'b1;
            @(negedge clk);
            digit_valid = 1'b0;
            start       = 1'b0;
            chk("wrem_hold", 32'(busy), 32'd1);
            chk("wrem_no_done", 32'(done), 32'd0);
        end
        rem_valid = 1'b1;
        rem_neg   = rn;
        sb.push_back(model(dg, rn));
        start = 1'b1;
        @(negedge clk);
        rem_valid = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("err_done", 32'(err), 32'(ill_seen));
        if (sb.size() != 0) chk("quotient", 32'(quotient), 32'(sb.pop_front()));
        @(negedge clk);
        start = 1'b0;
        chk("done_once", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("quot_hold", 32'(quotient), 32'(model(dg, rn)));
        chk("err_idle", 32'(err), 32'(ill_seen));
    endtask

    initial begin
        logic [DW-1:0] all1;
        all1        = {NDIG{3'b001}};
        rst         = 1'b1;
        start       = 1'b0;
        digit_valid = 1'b0;
        digit       = 3'b000;
        rem_valid   = 1'b0;
        rem_neg     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(digit_ready), 32'd0);
        rst = 1'b0;

        run(all1, 1'b0, 1'b0, 1'b0);
        run(all1, 1'b1, 1'b0, 1'b0);
        run({3'b010, 3'b110, {6{3'b000}}}, 1'b0, 1'b0, 1'b0);
        run({3'b111, {7{3'b000}}}, 1'b0, 1'b0, 1'b0);
        run(all1, 1'b0, 1'b1, 1'b1);
        run({{3{3'b001}}, 3'b011, {4{3'b001}}}, 1'b0, 1'b0, 1'b0);
        run(all1, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            digit_valid = 1'b1;
            digit       = 3'b001;
            @(negedge clk);
        end
        digit_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(digit_ready), 32'd0);
        chk("arst_quot", 32'(quotient), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run({3'b010, 3'b111, 3'b001, 3'b110,
             3'b000, 3'b010, 3'b001, 3'b111}, 1'b1, 1'b0, 1'b0);
        run({3'b110, 3'b010, 3'b111, 3'b000,
             3'b001, 3'b110, 3'b010, 3'b001}, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
